uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver, the receive half of the team's serial link and the counterpart of `uart_tx`. It oversamples the asynchronous `rx_serial` line on the system clock, recovers 8N1 frames (8E1 when parity is compiled in) and hands each byte to the core through a valid/ack handshake. It also flags framing, parity and overrun errors.

## Interface
- `Clkperbaud`, 1250: system clocks per bit period; must equal the transmitter's value; minimum 4, even values recommended.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial line; idles high.
- `rx_byte`  out  8  last received byte, LSB received first; stable while `rx_valid` is high.
- `rx_valid`  out  1  byte available; held until acknowledged.
- `rx_ack`  in  1  consumer accepts `rx_byte`; clears `rx_valid` on the next edge.
- `framing_err`  out  1  one-cycle pulse when the stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- `overrun_err`  out  1  one-cycle pulse when a new byte lands while `rx_valid` is still high.

## Operation
- `rx_serial` passes through a 2-flop synchronizer, giving `rx_sync`, with reset value 1. All decisions use `rx_sync`.
- States: IDLE, START, DATAIN, PARITY, STOP, CLEAN.
- IDLE: baud counter at 0 and bit index at 0. A low on `rx_sync` moves to START.
- START: count `Clkperbaud/2` clocks, then sample at mid-bit.
  - Sample low: go to DATAIN.
  - Sample high: glitch; return to IDLE with no output.
- DATAIN: count `Clkperbaud` clocks per bit and sample at each count end. Shift LSB-first into the shift register. After bit index 7, go to PARITY if enabled, else STOP.
- PARITY: count `Clkperbaud` clocks, then sample. Mismatch against even parity of the 8 data bits sets an internal parity flag. Go to STOP.
- STOP: count `Clkperbaud` clocks, then sample.
  - High: go to CLEAN with the frame good.
  - Low: pulse `framing_err`, discard the byte and go to CLEAN.
- CLEAN, good frame: lasts one cycle.
  - Load `rx_byte` and set `rx_valid`.
  - If `rx_valid` was already high and `rx_ack` is low, also pulse `overrun_err`. The new byte overwrites the old one.
  - If the parity flag is set, pulse `parity_err`. The byte is still delivered.
- CLEAN, framing error: stay until `rx_sync` is high (break condition), then go to IDLE.
- Handshake: `rx_ack` while `rx_valid` is high clears `rx_valid` next edge. `rx_ack` while `rx_valid` is low is ignored.
- Simultaneous `rx_ack` and a CLEAN load in the same cycle: the load wins. `rx_valid` stays 1, the new byte is presented and there is no overrun.
- Baud counter: `$clog2(Clkperbaud)` bits wide. It resets to 0 at every state transition and never wraps mid-bit.

## Timing
- Reset: all state is cleared, whether `rst` arrives in IDLE or mid-frame.
  - State returns to IDLE; `rx_byte`=0, `rx_valid`=0, and all error outputs are 0.
  - Synchronizer flops reset to 1.
  - Any partial frame is dropped.
- Sample points, counted from the first clock edge where `rx_serial` is low:
  - Start sample at +2+`Clkperbaud/2`.
  - Data bit k sampled at +2+`Clkperbaud/2`+(k+1)·`Clkperbaud`.
  - The bench allows ±1 clock on these points.
- Output latency: `rx_valid` rises one clock after the stop sample; error pulses share that edge.
- Back-to-back frames: after CLEAN the block re-enters IDLE. A start edge arriving half a bit after the stop-bit sample is caught.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present; frame is start + 8 data + even parity + stop (11 bits).
  - `parity_err` is live.
- Undefined:
  - PARITY state is removed and DATAIN goes straight to STOP (10-bit frame).
  - `parity_err` is tied 0.
- Must match the `uart_tx` build.

## Structure
- Shared package `uart_pkg` holds the state enum (shared with `uart_tx`), the `UART_DATA_W`=8 constant and the default `Clkperbaud`.
- Sub-module `uart_sync2`: generic 2-flop synchronizer with a reset value parameter.

## Test plan
Bench uses `Clkperbaud`=16.
- Reset idle: `rst` held 3 cycles, line high for 200 cycles → `rx_valid`=0, no error pulses, `rx_byte`=0.
- Good frame: send 0xAB 8N1 → `rx_valid` rises 1 clock after the stop sample with `rx_byte`=0xAB; `rx_ack` clears it next edge.
- Glitch: 4-cycle low pulse → back to IDLE, no `rx_valid`.
- Framing error: send 0x9D with stop bit low, then line low 40 cycles, then high → one `framing_err` pulse, `rx_valid`=0, next frame 0x55 received correctly.
- Overrun: send 0x11 then 0x22 without `rx_ack` → one `overrun_err` pulse and `rx_byte`=0x22. Repeat with `rx_ack` in the load cycle → no pulse.
- Parity (macro on): send 0x03 with parity bit 1 → `parity_err` pulse and `rx_byte`=0x03. Reset mid-DATAIN → clean recovery on the following 0xC3 frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx / uart_rx.
// Optional build macro used by the receiver: UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATAIN = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_CLEAN  = 3'd5
  } uart_state_e;

  localparam int UART_DATA_W         = 8;
  localparam int UART_CLKPERBAUD_DEF = 1250;

  // Even-parity bit for a data byte: 1 when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// Both flops take RESET_VAL under the synchronous active-high reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, or 8E1 when UART_RX_PARITY_EN is defined.
// Oversamples the synchronized line and delivers bytes through a valid/ack handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Clkperbaud = UART_CLKPERBAUD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_serial,
  output logic [UART_DATA_W-1:0] rx_byte,
  output logic                   rx_valid,
  input  logic                   rx_ack,
  output logic                   framing_err,
  output logic                   parity_err,
  output logic                   overrun_err
);

  localparam int CntW = $clog2(Clkperbaud);
  localparam int IdxW = $clog2(UART_DATA_W);
  localparam logic [CntW-1:0] HalfEnd = CntW'(Clkperbaud / 2 - 1);
  localparam logic [CntW-1:0] FullEnd = CntW'(Clkperbaud - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(UART_DATA_W - 1);

  uart_state_e            state_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        bit_idx_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [UART_DATA_W-1:0] byte_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   oerr_q;
  logic                   frame_bad_q;
  logic                   rx_sync;
  logic                   bit_end;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q;
  logic                   par_flag_q;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_serial),
    .q_o (rx_sync)
  );

  assign bit_end = (cnt_q == FullEnd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      oerr_q      <= 1'b0;
      frame_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      par_flag_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (rx_ack && valid_q) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          cnt_q       <= '0;
          bit_idx_q   <= '0;
          frame_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
          par_flag_q  <= 1'b0;
`endif
          if (!rx_sync) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == HalfEnd) begin
            cnt_q   <= '0;
            state_q <= rx_sync ? S_IDLE : S_DATAIN;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_DATAIN: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync, shift_q[UART_DATA_W-1:1]};
            bit_idx_q <= bit_idx_q + IdxW'(1);
            if (bit_idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q      <= '0;
            par_flag_q <= (rx_sync != even_parity(shift_q));
            state_q    <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q       <= '0;
            frame_bad_q <= !rx_sync;
            state_q     <= S_CLEAN;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_CLEAN: begin
          if (!frame_bad_q) begin
            // A load in the same cycle as rx_ack wins over the clear above.
            byte_q  <= shift_q;
            valid_q <= 1'b1;
            oerr_q  <= valid_q && !rx_ack;
`ifdef UART_RX_PARITY_EN
            perr_q  <= par_flag_q;
`endif
            state_q <= S_IDLE;
          end else begin
            // Counter marks the first CLEAN cycle so the error pulses once during a break.
            ferr_q <= (cnt_q == '0);
            cnt_q  <= CntW'(1);
            if (rx_sync) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_byte     = byte_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
  assign overrun_err = oerr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx with Clkperbaud=16.
// Honours UART_RX_PARITY_EN to match the frame format of the DUT build.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // rx_valid edge relative to the first low edge: stop sample plus one clock.
  localparam int LOAD_OFS = 2 + HALF + (NBITS - 1) * C + 1;

  logic       clk;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ack;
  logic       framing_err;
  logic       parity_err;
  logic       overrun_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int oerr_cnt = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int frame_start = 0;
  logic prev_valid = 1'b0;

  uart_rx #(.Clkperbaud(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and load-event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (framing_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (overrun_err === 1'b1) oerr_cnt++;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one complete frame; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
    logic b;
    @(negedge clk);
    frame_start = cyc + 1;
    for (int i = 0; i < NBITS; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= 8) b = d[i-1];
      else if (i == NBITS - 1) b = stop_bit;
      else b = (($countones(d) % 2) == 1) ^ par_bad;
      rx_serial = b;
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    int f0, p0, o0, r0, lat;
    logic [7:0] d;
    logic ack_first, par_bad, exp_valid, exp_perr;
    logic [7:0] exp_byte;
    int exp_oerr;

    rst = 1'b1;
    rx_serial = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_byte", rx_byte, 8'h00);
    check("reset_errs", ferr_cnt + perr_cnt + oerr_cnt, 0);

    // Good frame and latency
    send_frame(8'hAB, 1'b1, 1'b0);
    lat = rise_cyc - frame_start;
    check("valid_latency_ok", (lat >= LOAD_OFS - 1 && lat <= LOAD_OFS + 1), 1'b1);
    check("good_byte", rx_byte, 8'hAB);
    check("good_valid", rx_valid, 1'b1);
    do_ack();
    check("ack_clears", rx_valid, 1'b0);

    // Glitch
    r0 = rise_cnt;
    f0 = ferr_cnt;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_load", rise_cnt - r0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Framing error with break, then recovery
    r0 = rise_cnt;
    f0 = ferr_cnt;
    send_frame(8'h9D, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    check("framing_pulse", ferr_cnt - f0, 1);
    check("framing_no_valid", rx_valid, 1'b0);
    check("framing_no_load", rise_cnt - r0, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    check("after_break_byte", rx_byte, 8'h55);
    check("after_break_valid", rx_valid, 1'b1);
    do_ack();

    // Overrun without ack
    o0 = oerr_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("overrun_pulse", oerr_cnt - o0, 1);
    check("overrun_byte", rx_byte, 8'h22);
    do_ack();

    // Ack coinciding with the load: load wins, no overrun
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    o0 = oerr_cnt;
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (LOAD_OFS) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("ack_load_no_overrun", oerr_cnt - o0, 0);
    check("ack_load_valid", rx_valid, 1'b1);
    check("ack_load_byte", rx_byte, 8'h22);
    do_ack();

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("parity_pulse", perr_cnt - p0, 1);
    check("parity_byte", rx_byte, 8'h03);
    do_ack();
`endif

    // Reset in the middle of a data phase
    f0 = ferr_cnt;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (C) @(negedge clk);
    rx_serial = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("midreset_valid", rx_valid, 1'b0);
    check("midreset_byte", rx_byte, 8'h00);
    send_frame(8'hC3, 1'b1, 1'b0);
    check("midreset_recover_byte", rx_byte, 8'hC3);
    check("midreset_recover_valid", rx_valid, 1'b1);
    check("midreset_no_ferr", ferr_cnt - f0, 0);

    // Randomized frames against a transaction-level model
    exp_valid = 1'b1;
    exp_byte = 8'hC3;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom_range(0, 255));
      ack_first = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
      par_bad = 1'($urandom_range(0, 1));
`else
      par_bad = 1'b0;
`endif
      if (ack_first) begin
        do_ack();
        exp_valid = 1'b0;
      end
      repeat ($urandom_range(2, 30)) @(negedge clk);
      f0 = ferr_cnt;
      p0 = perr_cnt;
      o0 = oerr_cnt;
      send_frame(d, 1'b1, par_bad);
      repeat (2) @(negedge clk);
      exp_oerr = exp_valid ? 1 : 0;
      exp_perr = par_bad;
      exp_valid = 1'b1;
      exp_byte = d;
      check("rand_byte", rx_byte, exp_byte);
      check("rand_valid", rx_valid, exp_valid);
      check("rand_overrun", oerr_cnt - o0, exp_oerr);
      check("rand_parity", perr_cnt - p0, exp_perr);
      check("rand_no_ferr", ferr_cnt - f0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
